// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control-token constants, token decode helper and aligner FSM state enum.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctrl;
  } token_info_t;

  function automatic token_info_t token_decode(input logic [9:0] word);
    token_info_t info;
    info.is_token = 1'b1;
    info.ctrl     = 2'b00;
    case (word)
      TOKEN_C00: info.ctrl = 2'b00;
      TOKEN_C01: info.ctrl = 2'b01;
      TOKEN_C10: info.ctrl = 2'b10;
      TOKEN_C11: info.ctrl = 2'b11;
      default:   info.is_token = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - per-channel TMDS bit-slip word aligner (SDR/DDR input).
// Optional slip counter port out_slip_count under macro TMDS_ALIGN_SLIP_COUNT_EN.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter bit C_ddr        = 1'b0,
  parameter int C_lock_count = 8,
  parameter int C_hunt_words = 16,
  parameter int C_timeout    = 4096
) (
  input  logic       clk_shift,
  input  logic       rst_n,
  input  logic [1:0] in_bits,
  output logic [9:0] out_word,
  output logic       out_valid,
  output logic       out_locked,
  output logic       out_de,
  output logic [1:0] out_ctrl
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
  ,
  output logic [7:0] out_slip_count
`endif
);

  localparam int MATCH_W = $clog2(C_lock_count + 1);
  localparam int MISS_W  = $clog2(C_hunt_words + 1);
  localparam int IDLE_W  = $clog2(C_timeout + 1);
  localparam logic [3:0] PH_LAST = C_ddr ? 4'd4 : 4'd9;

  logic [19:0]        sr_q, sr_d;
  logic [3:0]         ph_q, ph_d;
  logic               h_q, h_d;
  logic               hold_q, hold_d;
  align_state_e       state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [9:0]         word_q, word_d;
  logic               valid_q, valid_d;
  logic               de_q, de_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               strobe;
  logic               slip;
  logic [9:0]         cand;
  token_info_t        tok;

  always_comb begin
    sr_d    = C_ddr ? {in_bits[1], in_bits[0], sr_q[19:2]} : {in_bits[0], sr_q[19:1]};
    strobe  = (ph_q == PH_LAST);
    // The candidate includes the bit sampled on this edge; h selects the one-bit-older window.
    cand    = (C_ddr && h_q) ? sr_d[18:9] : sr_d[19:10];
    tok     = token_decode(cand);
    ph_d    = hold_q ? ph_q : (strobe ? 4'd0 : ph_q + 4'd1);
    h_d     = h_q;
    hold_d  = 1'b0;
    slip    = 1'b0;
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    idle_d  = idle_q;
    word_d  = word_q;
    valid_d = strobe;
    de_d    = de_q;
    ctrl_d  = ctrl_q;
    if (strobe) begin
      word_d = cand;
      de_d   = ~tok.is_token;
      if (tok.is_token) ctrl_d = tok.ctrl;
      case (state_q)
        ST_HUNT: begin
          if (tok.is_token) begin
            miss_d = '0;
            if (match_q == MATCH_W'(C_lock_count - 1)) begin
              state_d = ST_LOCKED;
              match_d = '0;
              idle_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
            if (miss_q == MISS_W'(C_hunt_words - 1)) begin
              slip   = 1'b1;
              miss_d = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (tok.is_token) begin
            idle_d = '0;
          end else if (idle_q == IDLE_W'(C_timeout - 1)) begin
            state_d = ST_HUNT;
            idle_d  = '0;
            match_d = '0;
            miss_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    // DDR slips alternate a half-bit window shift with a full-cycle phase hold.
    if (slip) begin
      hold_d = C_ddr ? h_q : 1'b1;
      h_d    = C_ddr ? ~h_q : h_q;
    end
  end

  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      ph_q    <= '0;
      h_q     <= 1'b0;
      hold_q  <= 1'b0;
      state_q <= ST_HUNT;
      match_q <= '0;
      miss_q  <= '0;
      idle_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      de_q    <= 1'b0;
      ctrl_q  <= 2'b00;
    end else begin
      sr_q    <= sr_d;
      ph_q    <= ph_d;
      h_q     <= h_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      idle_q  <= idle_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      de_q    <= de_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_word   = word_q;
  assign out_valid  = valid_q;
  assign out_locked = (state_q == ST_LOCKED);
  assign out_de     = de_q;
  assign out_ctrl   = ctrl_q;

`ifdef TMDS_ALIGN_SLIP_COUNT_EN
  logic [7:0] slip_cnt_q, slip_cnt_d;

  always_comb begin
    slip_cnt_d = slip_cnt_q;
    if (slip && (slip_cnt_q != 8'hFF)) slip_cnt_d = slip_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) slip_cnt_q <= 8'd0;
    else        slip_cnt_q <= slip_cnt_d;
  end

  assign out_slip_count = slip_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_word_aligner.sv
// tb/tb_tmds_word_aligner.sv - randomized self-checking bench for tmds_word_aligner (SDR and DDR instances).
// Also checks out_slip_count when TMDS_ALIGN_SLIP_COUNT_EN is defined.
module tb_tmds_word_aligner;

  localparam int LOCK_N    = 8;
  localparam int HUNT_N    = 16;
  localparam int TIMEOUT_N = 4096;
  localparam int HB        = 131072;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  [2];
  logic [1:0] in_b   [2];
  logic [9:0] o_word [2];
  logic       o_valid[2];
  logic       o_locked[2];
  logic       o_de   [2];
  logic [1:0] o_ctrl [2];
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
  logic [7:0] o_slip [2];
`endif

  tmds_word_aligner #(.C_ddr(1'b0), .C_lock_count(LOCK_N), .C_hunt_words(HUNT_N), .C_timeout(TIMEOUT_N)) u_sdr (
    .clk_shift(clk), .rst_n(rst_n[0]), .in_bits(in_b[0]),
    .out_word(o_word[0]), .out_valid(o_valid[0]), .out_locked(o_locked[0]),
    .out_de(o_de[0]), .out_ctrl(o_ctrl[0])
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    , .out_slip_count(o_slip[0])
`endif
  );

  tmds_word_aligner #(.C_ddr(1'b1), .C_lock_count(LOCK_N), .C_hunt_words(HUNT_N), .C_timeout(TIMEOUT_N)) u_ddr (
    .clk_shift(clk), .rst_n(rst_n[1]), .in_bits(in_b[1]),
    .out_word(o_word[1]), .out_valid(o_valid[1]), .out_locked(o_locked[1]),
    .out_de(o_de[1]), .out_ctrl(o_ctrl[1])
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    , .out_slip_count(o_slip[1])
`endif
  );

  int tests = 0;
  int fails = 0;

  bit txb [2][HB];
  int tx_rd[2];
  int tx_wr[2];
  bit hist[2][HB];
  int nbits[2];
  bit active[2];
  int cyc[2];

  // Word-level reference: m_end is the bit index (1-based) of the last bit of the next word.
  int         m_end[2];
  bit         m_h[2];
  bit         m_locked[2];
  int         m_match[2];
  int         m_miss[2];
  int         m_idle[2];
  logic [1:0] m_ctrl[2];
  int         m_slips[2];

  int vcount[2];
  int last_vcyc[2];
  int period[2];
  int nontok_run[2];
  int last_run[2];

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  function automatic bit is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] ctrl_of(input logic [9:0] w);
    case (w)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [9:0] window(input int d, input int e);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[k] = hist[d][e - 10 + k];
    return w;
  endfunction

  function automatic int vcyc(input int d, input int e);
    return (d == 0) ? e : (e + 1) / 2;
  endfunction

  function automatic bit pop(input int d);
    bit b;
    if (tx_rd[d] < tx_wr[d]) begin
      b = txb[d][tx_rd[d]];
      tx_rd[d]++;
    end else begin
      b = 1'($urandom);
    end
    return b;
  endfunction

  task automatic push_bit(input int d, input bit b);
    if (tx_wr[d] < HB) begin
      txb[d][tx_wr[d]] = b;
      tx_wr[d]++;
    end
  endtask

  task automatic push_word(input int d, input logic [9:0] w);
    for (int k = 0; k < 10; k++) push_bit(d, w[k]);
  endtask

  // r leading bits taken from the token tail, so symbol boundaries sit r bits in.
  task automatic push_stream(input int d, input logic [9:0] tok, input int r, input int n);
    for (int k = 10 - r; k < 10; k++) push_bit(d, tok[k]);
    for (int j = 0; j < n; j++) push_word(d, tok);
  endtask

  task automatic push_data(input int d, input int n);
    logic [9:0] w;
    for (int j = 0; j < n; j++) begin
      w = 10'($urandom);
      while (is_token(w)) w = 10'($urandom);
      push_word(d, w);
    end
  endtask

  task automatic mreset(input int d);
    m_end[d] = 10; m_h[d] = 1'b0; m_locked[d] = 1'b0;
    m_match[d] = 0; m_miss[d] = 0; m_idle[d] = 0; m_ctrl[d] = 2'b00; m_slips[d] = 0;
    cyc[d] = 0; nbits[d] = 0;
    vcount[d] = 0; last_vcyc[d] = 0; period[d] = 0; nontok_run[d] = 0; last_run[d] = 0;
  endtask

  task automatic model_word(input int d);
    logic [9:0] w;
    bit tok;
    bit slip;
    slip = 1'b0;
    w    = window(d, m_end[d]);
    tok  = is_token(w);
    if (!m_locked[d]) begin
      if (tok) begin
        m_miss[d] = 0;
        m_match[d]++;
        if (m_match[d] == LOCK_N) begin m_locked[d] = 1'b1; m_match[d] = 0; m_idle[d] = 0; end
      end else begin
        m_match[d] = 0;
        m_miss[d]++;
        if (m_miss[d] == HUNT_N) begin slip = 1'b1; m_miss[d] = 0; end
      end
    end else if (tok) begin
      m_idle[d] = 0;
    end else begin
      m_idle[d]++;
      if (m_idle[d] == TIMEOUT_N) begin
        m_locked[d] = 1'b0; m_idle[d] = 0; m_match[d] = 0; m_miss[d] = 0;
      end
    end
    if (tok) m_ctrl[d] = ctrl_of(w);
    if (slip && m_slips[d] < 255) m_slips[d]++;
    check("valid", d, o_valid[d], 1);
    check("word", d, o_word[d], w);
    check("de", d, o_de[d], !tok);
    check("ctrl", d, o_ctrl[d], m_ctrl[d]);
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    check("slip_count", d, o_slip[d], m_slips[d]);
`endif
    if (!slip)       m_end[d] += 10;
    else if (d == 0) m_end[d] += 11;
    else begin
      m_end[d] += m_h[d] ? 13 : 9;
      m_h[d] = !m_h[d];
    end
  endtask

  task automatic per_cycle(input int d);
    if (cyc[d] == vcyc(d, m_end[d])) model_word(d);
    else check("valid_idle", d, o_valid[d], 0);
    check("locked", d, o_locked[d], m_locked[d]);
    if (o_valid[d]) begin
      vcount[d]++;
      period[d] = cyc[d] - last_vcyc[d];
      last_vcyc[d] = cyc[d];
      if (o_de[d]) nontok_run[d]++;
      else begin last_run[d] = nontok_run[d]; nontok_run[d] = 0; end
    end
  endtask

  task automatic drive(input int d);
    logic [1:0] b;
    b[0] = pop(d);
    b[1] = (d == 1) ? pop(d) : 1'($urandom);
    in_b[d] = b;
    if (active[d]) begin
      if (nbits[d] < HB) begin hist[d][nbits[d]] = b[0]; nbits[d]++; end
      if (d == 1 && nbits[d] < HB) begin hist[d][nbits[d]] = b[1]; nbits[d]++; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) if (active[d]) begin cyc[d]++; per_cycle(d); end
    for (int d = 0; d < 2; d++) drive(d);
  endtask

  task automatic release_dut(input int d, input logic [9:0] tok, input int r, input int n);
    tx_rd[d] = 0;
    tx_wr[d] = 0;
    push_stream(d, tok, r, n);
    mreset(d);
    rst_n[d] = 1'b1;
    active[d] = 1'b1;
    drive(d);
  endtask

  task automatic check_zero(input int d);
    check("rst_word", d, o_word[d], 0);
    check("rst_valid", d, o_valid[d], 0);
    check("rst_locked", d, o_locked[d], 0);
    check("rst_de", d, o_de[d], 0);
    check("rst_ctrl", d, o_ctrl[d], 0);
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    check("rst_slip", d, o_slip[d], 0);
`endif
  endtask

  task automatic wait_lock(input int d, input int budget);
    int n;
    n = 0;
    while (o_locked[d] !== 1'b1 && n < budget) begin tick(); n++; end
    check("lock_reached", d, o_locked[d], 1);
  endtask

  logic [9:0] toks[4];
  logic [9:0] tok_d;
  int r_d;
  int n;

  initial begin
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_b[d] = 2'b00; active[d] = 1'b0;
      tx_rd[d] = 0; tx_wr[d] = 0; mreset(d);
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) check_zero(d);

    // SDR aligned 354 stream; DDR random token at a random offset.
    tok_d = toks[$urandom_range(0, 3)];
    r_d   = $urandom_range(0, 9);
    release_dut(0, 10'h354, 0, 200);
    release_dut(1, tok_d, r_d, 400);
    wait_lock(0, 3000);
    check("s1_lock_valid_idx", 0, vcount[0], 8);
    check("s1_valid", 0, o_valid[0], 1);
    check("s1_word", 0, o_word[0], 10'h354);
    check("s1_ctrl", 0, o_ctrl[0], 2'b00);
    check("s1_de", 0, o_de[0], 0);
    check("s1_period", 0, period[0], 10);
    wait_lock(1, 3000);
    check("s1_word", 1, o_word[1], tok_d);
    check("s1_period", 1, period[1], 5);

    // SDR misaligned by 3 bits: three slips of 16 misses each, then 8 tokens.
    rst_n[0] = 1'b0; active[0] = 1'b0;
    tick(); tick();
    release_dut(0, 10'h0AB, 3, 200);
    wait_lock(0, 3000);
    check("s2_lock_valid_idx", 0, vcount[0], 3 * HUNT_N + LOCK_N);
    check("s2_lock_cycle", 0, cyc[0], (3 * HUNT_N + LOCK_N) * 10 + 3);
    check("s2_word", 0, o_word[0], 10'h0AB);
    check("s2_ctrl", 0, o_ctrl[0], 2'b01);
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    check("s2_slips", 0, o_slip[0], 3);
`endif

    // One-cycle reset while locked, then relock on a fresh aligned stream.
    rst_n[0] = 1'b0; active[0] = 1'b0;
    #1;
    check_zero(0);
    tick();
    release_dut(0, 10'h0AB, 0, 100);
    wait_lock(0, 1000);
    check("s5_relock_idx", 0, vcount[0], LOCK_N);
    check("s5_word", 0, o_word[0], 10'h0AB);

    // DDR odd bit offset with 2AB.
    rst_n[1] = 1'b0; active[1] = 1'b0;
    tick(); tick();
    r_d = 2 * $urandom_range(0, 4) + 1;
    release_dut(1, 10'h2AB, r_d, 300);
    wait_lock(1, 3000);
    check("s3_word", 1, o_word[1], 10'h2AB);
    check("s3_ctrl", 1, o_ctrl[1], 2'b11);
    check("s3_period", 1, period[1], 5);

    // Locked DDR: 4095 data words, then 154 tokens, then 4096 data words.
    push_data(1, TIMEOUT_N - 1);
    push_stream(1, 10'h154, 0, 9);
    push_data(1, TIMEOUT_N + 8);
    n = 0;
    while (!(o_valid[1] === 1'b1 && o_de[1] === 1'b1) && n < 3000) begin tick(); n++; end
    check("s4_data_de", 1, o_de[1], 1);
    check("s4_data_locked", 1, o_locked[1], 1);
    check("s4_data_ctrl_hold", 1, o_ctrl[1], 2'b11);
    n = 0;
    while (!(o_valid[1] === 1'b1 && o_de[1] === 1'b0) && n < 25000) begin tick(); n++; end
    check("s4_tok_locked", 1, o_locked[1], 1);
    check("s4_tok_word", 1, o_word[1], 10'h154);
    check("s4_tok_ctrl", 1, o_ctrl[1], 2'b10);
    check("s4_data_run", 1, last_run[1], TIMEOUT_N - 1);
    n = 0;
    while (o_locked[1] === 1'b1 && n < 25000) begin tick(); n++; end
    check("s4_unlock", 1, o_locked[1], 0);
    check("s4_unlock_valid", 1, o_valid[1], 1);
    check("s4_unlock_run", 1, nontok_run[1], TIMEOUT_N);
    check("s4_unlock_ctrl", 1, o_ctrl[1], 2'b10);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tmds_word_aligner.md
# tmds_word_aligner

Receive-side counterpart of the fake-differential TMDS output stage. Takes one TMDS channel's single-ended samples from the input pins, 1 bit per cycle in SDR or 2 bits per cycle in DDR, and shifts them into 10-bit symbols. It finds the symbol boundary by bit-slipping until DVI control tokens line up, and emits aligned symbols with a valid strobe, a lock flag and the decoded control/DE state. One instance sits per channel, ahead of the TMDS 8b/10b decoder.

## Interface
- C_ddr, 1'b0: 0 = SDR (1 bit/cycle, `in_bits[0]` only); 1 = DDR (2 bits/cycle).
- C_lock_count, 8: consecutive aligned control tokens required to declare lock.
- C_hunt_words, 16: consecutive non-token words in HUNT before one bit slip.
- C_timeout, 4096: consecutive non-token words in LOCKED before lock is dropped.
- clk_shift  in  1  bit clock in SDR, half bit clock in DDR; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_bits  in  2  pin samples; [0] is the earlier bit in time (DDR D0), [1] the later; TMDS LSB first.
- out_word  out  10  aligned TMDS symbol, bit 0 = first received.
- out_valid  out  1  one-cycle strobe per symbol.
- out_locked  out  1  alignment achieved.
- out_de  out  1  0 when out_word is a control token, else 1.
- out_ctrl  out  2  decoded {c1,c0} of the last control token; holds while out_de = 1.
- out_slip_count  out  8  only with TMDS_ALIGN_SLIP_COUNT_EN.

## Operation
- Shift register sr[19:0]. Each cycle, SDR: sr <= {in_bits[0], sr[19:1]}. DDR: sr <= {in_bits[1], in_bits[0], sr[19:2]}.
- Phase counter counts 0..9 (SDR) or 0..4 (DDR). The strobe fires at the terminal count.
- Word at the strobe: sr[19:10], or sr[18:9] when the DDR half-bit offset h = 1.
- Slip, SDR: the phase counter holds for one cycle.
- Slip, DDR: h toggles. On the 1->0 transition the phase counter also holds one cycle.
- Ten consecutive slips visit every bit offset and return to the original one.
- Control tokens and their {c1,c0} decode: 10'h354 -> 00, 10'h0AB -> 01, 10'h154 -> 10, 10'h2AB -> 11.
- FSM states are HUNT (reset state) and LOCKED. State changes are evaluated only on strobes.
- HUNT, token word: match_cnt++ and miss_cnt := 0. When match_cnt reaches C_lock_count, go to LOCKED and set idle_cnt := 0.
- HUNT, non-token word: match_cnt := 0 and miss_cnt++. When miss_cnt reaches C_hunt_words, issue one slip and set miss_cnt := 0.
- LOCKED, token word: idle_cnt := 0.
- LOCKED, non-token word: idle_cnt++. When idle_cnt reaches C_timeout, go to HUNT and clear match_cnt and miss_cnt.
- LOCKED never slips.
- Counter widths are $clog2(limit+1). Counters never wrap; each clears exactly at its limit.
- Symbols are emitted in both states; consumers qualify with out_locked.

## Timing
- Reset values: every output 0, FSM = HUNT, all counters 0, h = 0, sr = 0.
- out_word, out_valid, out_de and out_ctrl are registered. out_valid is high in the cycle after the strobe cycle, which is the cycle the symbol's last bit is sampled.
- out_valid period is exactly 10 cycles (SDR) or 5 cycles (DDR). The single exception is a slip, which stretches one period by 1 cycle (SDR) or by 0/1 cycle (DDR, depending on h).
- out_locked rises together with out_valid of the C_lock_count-th consecutive token.
- out_locked falls together with out_valid of the C_timeout-th non-token word.
- A slip decided on a strobe affects the next word only. That next word counts as a fresh miss/match.
- rst_n asserted mid-operation clears everything immediately; alignment restarts from HUNT.

## Configuration
- Macro TMDS_ALIGN_SLIP_COUNT_EN.
- Defined: out_slip_count is an 8-bit counter of slips since reset. It saturates at 255 and is cleared by reset only.
- Undefined: the port and the counter are absent.

## Structure
- Shared package tmds_pkg holds:
  - the four control-token constants;
  - a function mapping a token to {c1,c0};
  - the FSM state enum.
- The aligner is a single module with no sub-modules. The token lookup is a package function.

## Test plan
- SDR, alignment at offset 0: drive a repeating 10'h354 stream. Required: out_locked rises on the 8th out_valid, out_ctrl = 00, out_de = 0, period 10 cycles.
- SDR, misaligned by 3 bits: drive a 10'h0AB stream. Required: slips occur every 16 words until aligned, then lock with out_ctrl = 01, out_word = 10'h0AB, and (with the macro) out_slip_count = the number of slips taken (expected 3 or 7, per the chosen offset direction).
- DDR, odd bit offset: drive a 10'h2AB stream. Required: lock with out_word = 10'h2AB and out_valid period 5 cycles.
- Locked, then active data: drive 4095 non-token words followed by one 10'h154. Required: lock held, out_de = 1 during data, out_ctrl = 10 afterwards.
- Locked, then 4096 non-token words. Required: out_locked falls with the 4096th out_valid.
- Assert rst_n low for 1 cycle while locked. Required: all outputs 0 at once; relock after 8 further tokens.
